// File: rtl/spi_reg_master.sv
// SPI mode-0 initiator for two-byte register transactions: {write, addr} then wdata/0x00.
// The second byte shifted in on miso is returned on rdata when done pulses.
module spi_reg_master #(
    parameter int unsigned CLKDIV    = 4,
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       write,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned BIT_WIDTH  = 5;
    localparam logic [DIV_WIDTH-1:0] DIV_RELOAD = DIV_WIDTH'(CLKDIV - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST2  = DIV_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] BIT_LAST   = BIT_WIDTH'(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        GAP
    } state_t;

    state_t                 state;
    logic [DIV_WIDTH-1:0]   div_cnt;
    logic [BIT_WIDTH-1:0]   bit_cnt;
    logic [FRAME_BITS-1:0]  tx_sr;
    logic [7:0]             rx_sr;
    logic                   pend;
    logic                   phase_end;
    logic [FRAME_BITS-1:0]  frame_c;

    assign phase_end = (div_cnt == '0);
    assign frame_c   = {write, addr, (write ? wdata : 8'h00)};

    // Every non-idle phase lasts CLKDIV cycles; the counter reloads at each phase boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= DIV_RELOAD;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            pend    <= 1'b0;
            rdata   <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            ss      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            done    <= 1'b0;
            div_cnt <= (state == IDLE || phase_end) ? DIV_RELOAD : div_cnt - 1'b1;

            case (state)
                IDLE: begin
                    if (pend || start) begin
                        if (!pend) begin
                            tx_sr <= frame_c;
                        end
                        mosi    <= pend ? tx_sr[FRAME_BITS-1] : write;
                        pend    <= 1'b0;
                        ss      <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_end) begin
                        state <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) begin
                        sclk    <= 1'b1;
                        rx_sr   <= {rx_sr[6:0], miso};
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        sclk <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= HOLD;
                        end else begin
                            tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                            mosi  <= tx_sr[FRAME_BITS-2];
                            state <= SHIFT_LO;
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        ss    <= 1'b1;
                        mosi  <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    // The final gap cycle is the done cycle; a start seen there launches next.
                    if (div_cnt == DIV_LAST2) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        rdata <= rx_sr;
                    end
                    if (phase_end) begin
                        state <= IDLE;
                        if (start) begin
                            tx_sr <= frame_c;
                            pend  <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
